branch_predict_ctrl: RTL and testbench

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/branch_predict_ctrl.sv | 116 +++++++++++
 tb/tb_branch_predict_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Purpose: bimodal 2-bit branch direction predictor with EX-stage resolve, flush/redirect FSM and stats.
// Latency: pred_taken is zero-cycle from if_pc; counter/stat updates land on the next clk edge.
// Backpressure: stall freezes resolve handling (no updates, no flush); a pending FLUSH cycle completes regardless.
module branch_predict_ctrl #(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic [1:0]  ex_kind,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ctr_q [ENTRIES];
    logic [1:0]  ctr_d [ENTRIES];
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mis_count_q, mis_count_d;

    logic [IDXW-1:0] if_idx;
    logic [IDXW-1:0] ex_idx;
    logic            is_cond;
    logic            is_jump;
    logic            resolve;
    logic            mispredict;
    logic [31:0]     pc_plus4;
    logic            unused_pc_bits;

    assign if_idx         = if_pc[IDXW+1:2];
    assign ex_idx         = ex_pc[IDXW+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDXW+2], if_pc[1:0]};

    // Decode the EX instruction and derive the combinational control outputs.
    always_comb begin
        is_cond    = (ex_kind == 2'b01);
        is_jump    = ex_kind[1];
        resolve    = ex_valid && !stall && (state_q == IDLE) && (ex_kind != 2'b00);
        mispredict = resolve && ((is_cond && (ex_taken != ex_pred_taken)) ||
                                 (is_jump && !ex_pred_taken));
        pc_plus4   = ex_pc + 32'd4;
        // Taken branches and all jumps go to the target; a wrongly-predicted-taken branch falls through.
        redirect_pc    = (mispredict && (ex_taken || is_jump)) ? ex_target : pc_plus4;
        // Reset masks any flush/redirect so a mispredict on the inputs cannot leak out.
        redirect_valid = rst_n && mispredict;
        flush          = rst_n && (mispredict || (state_q == FLUSH));
        pred_taken     = ctr_q[if_idx][1];
    end

    // Next-state logic: FLUSH lasts exactly one cycle and always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mispredict) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating counter training and saturating statistics for resolved branches.
    always_comb begin
        ctr_d       = ctr_q;
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (resolve && is_cond) begin
            if (ex_taken && (ctr_q[ex_idx] != 2'b11)) begin
                ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
            end else if (!ex_taken && (ctr_q[ex_idx] != 2'b00)) begin
                ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
            if (br_count_q != 32'hFFFF_FFFF) begin
                br_count_d = br_count_q + 32'd1;
            end
        end
        if (mispredict && (mis_count_q != 32'hFFFF_FFFF)) begin
            mis_count_d = mis_count_q + 32'd1;
        end
    end

    // State registers; reset puts every counter at weak not-taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            br_count_q  <= 32'd0;
            mis_count_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            state_q     <= state_d;
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
            ctr_q       <= ctr_d;
        end
    end

    assign br_count  = br_count_q;
    assign mis_count = mis_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Purpose: self-checking bench for branch_predict_ctrl against a behavioural predictor model.
// Latency: outputs sampled on the falling edge; model advances on each rising edge.
// Backpressure: stall driven directed and randomly; FLUSH-cycle blocking checked.
module tb_branch_predict_ctrl;

    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [1:0]  ex_kind;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Behavioural model: counter values 0..3, a one-cycle "flush pending" flag and plain counts.
    int          m_ctr [ENTRIES];
    bit          m_in_flush = 1'b0;
    logic [31:0] m_br  = 32'd0;
    logic [31:0] m_mis = 32'd0;

    branch_predict_ctrl #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .stall(stall),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .br_count(br_count), .mis_count(mis_count)
    );

    always #20 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_ctr[idx_of(pc)] >= 2;
    endfunction

    function automatic bit exp_resolve();
        return rst_n && ex_valid && !stall && !m_in_flush && (ex_kind != 2'b00);
    endfunction

    function automatic bit exp_misp();
        if (!exp_resolve()) return 1'b0;
        if (ex_kind == 2'b01) return ex_taken != ex_pred_taken;
        return !ex_pred_taken;
    endfunction

    function automatic bit exp_flush();
        return rst_n && (exp_misp() || m_in_flush);
    endfunction

    function automatic logic [31:0] exp_rpc();
        logic [31:0] r;
        r = ((ex_kind == 2'b10) || (ex_kind == 2'b11) || ex_taken) ? ex_target : ex_pc + 32'd4;
        return r;
    endfunction

    task automatic drive_idle();
        ex_valid = 1'b0; ex_kind = 2'b00; ex_pc = 32'h0; ex_target = 32'h0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0; stall = 1'b0;
    endtask

    task automatic drive_ex(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic pt);
        ex_valid = 1'b1; ex_kind = k; ex_pc = pc; ex_target = tgt;
        ex_taken = tk; ex_pred_taken = pt; stall = 1'b0;
    endtask

    // Advance one clock: the model consumes the inputs present before the edge.
    task automatic tick();
        bit          res, misp, rst_c, cond;
        int          idx;
        logic        tk;
        res   = exp_resolve();
        misp  = exp_misp();
        rst_c = rst_n;
        cond  = (ex_kind == 2'b01);
        idx   = idx_of(ex_pc);
        tk    = ex_taken;
        @(posedge clk);
        if (!rst_c) begin
            for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
            m_in_flush = 1'b0; m_br = 32'd0; m_mis = 32'd0;
        end else begin
            if (res && cond) begin
                if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
            end
            if (misp && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
            m_in_flush = misp;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_ex(2'b01, 32'h100, 32'h800, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
        tick();
        tick();
        rst_n = 1'b1; drive_idle(); if_pc = 32'h40;
        @(negedge clk);
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
        n_tests++; if (br_count !== 32'd0) begin n_fail++; $display("FAIL reset_br: got %0d want 0", br_count); end
        n_tests++; if (mis_count !== 32'd0) begin n_fail++; $display("FAIL reset_mis: got %0d want 0", mis_count); end
        tick();
    endtask

    task automatic test_train();
        if_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            drive_ex(2'b01, 32'h40, 32'h80, 1'b1, 1'b1);
            @(negedge clk);
            n_tests++; if (pred_taken !== m_pred(32'h40)) begin n_fail++; $display("FAIL train_pred[%0d]: got %b want %b", i, pred_taken, m_pred(32'h40)); end
            n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL train_flush[%0d]: got %b want 0", i, flush); end
            tick();
        end
        drive_idle();
        @(negedge clk);
        n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_final_pred: got %b want 1", pred_taken); end
        n_tests++; if (br_count !== 32'd4) begin n_fail++; $display("FAIL train_br: got %0d want 4", br_count); end
        tick();
    endtask

    task automatic test_mispredict();
        drive_ex(2'b01, 32'h100, 32'h999, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL misp_flush_T: got %b want 1", flush); end
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL misp_rv_T: got %b want 1", redirect_valid); end
        n_tests++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL misp_rpc: got %h want 00000104", redirect_pc); end
        tick();
        drive_idle();
        @(negedge clk);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL misp_flush_T1: got %b want 1", flush); end
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL misp_rv_T1: got %b want 0", redirect_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL misp_flush_T2: got %b want 0", flush); end
        n_tests++; if (mis_count !== 32'd1) begin n_fail++; $display("FAIL misp_count: got %0d want 1", mis_count); end
        tick();
    endtask

    task automatic test_jump();
        logic [31:0] br_before, mis_before;
        drive_ex(2'b10, 32'h300, 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        br_before = m_br;
        n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jump_rv: got %b want 1", redirect_valid); end
        n_tests++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL jump_rpc: got %h want 00000200", redirect_pc); end
        tick();
        mis_before = m_mis;
        drive_ex(2'b01, 32'h0, 32'h600, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush_T1: got %b want 1", flush); end
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jump_rv_T1: got %b want 0", redirect_valid); end
        tick();
        drive_idle();
        @(negedge clk);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jump_flush_T2: got %b want 0", flush); end
        n_tests++; if (br_count !== br_before) begin n_fail++; $display("FAIL jump_br: got %0d want %0d", br_count, br_before); end
        n_tests++; if (mis_count !== mis_before) begin n_fail++; $display("FAIL jump_mis: got %0d want %0d", mis_count, mis_before); end
        for (int i = 0; i < ENTRIES; i++) begin
            if_pc = 32'(i * 4);
            #1;
            n_tests++; if (pred_taken !== m_pred(if_pc)) begin n_fail++; $display("FAIL jump_scan[%0d]: got %b want %b", i, pred_taken, m_pred(if_pc)); end
        end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] br_before, mis_before;
        br_before = m_br; mis_before = m_mis;
        drive_ex(2'b01, 32'h140, 32'h500, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out[%0d]: got flush=%b rv=%b want 0/0", i, flush, redirect_valid); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (br_count !== br_before || mis_count !== mis_before) begin n_fail++; $display("FAIL stall_counts: got %0d/%0d want %0d/%0d", br_count, mis_count, br_before, mis_before); end
        stall = 1'b0;
        #1;
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500) begin n_fail++; $display("FAIL stall_release: got rv=%b pc=%h want 1/00000500", redirect_valid, redirect_pc); end
        tick();
        drive_idle();
        @(negedge clk);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL stall_flush_T1: got %b want 1", flush); end
        tick();
    endtask

    task automatic test_wrap();
        drive_ex(2'b01, 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (redirect_pc !== 32'h0 || redirect_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_rpc: got rv=%b pc=%h want 1/00000000", redirect_valid, redirect_pc); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_reset_in_flush();
        drive_ex(2'b11, 32'h40, 32'h700, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0; drive_idle();
        @(negedge clk);
        n_tests++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rif_out: got flush=%b rv=%b want 0/0", flush, redirect_valid); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rif_flush_after: got %b want 0", flush); end
        n_tests++; if (mis_count !== 32'd0 || br_count !== 32'd0) begin n_fail++; $display("FAIL rif_counts: got %0d/%0d want 0/0", br_count, mis_count); end
        for (int i = 0; i < ENTRIES; i++) begin
            if_pc = 32'(i * 4);
            #1;
            n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rif_scan[%0d]: got %b want 0", i, pred_taken); end
        end
        tick();
    endtask

    task automatic test_random();
        int          k;
        logic [31:0] exp_pc;
        for (int c = 0; c < 600; c++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            if_pc    = $urandom();
            ex_valid = ($urandom_range(0, 4) != 0);
            ex_kind  = 2'($urandom_range(0, 3));
            ex_pc    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom();
            ex_target = $urandom();
            ex_taken = 1'($urandom_range(0, 1));
            k        = $urandom_range(0, 9);
            ex_pred_taken = (k < 7) ? m_pred(ex_pc) : 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            exp_pc = exp_rpc();
            n_tests++; if (pred_taken !== m_pred(if_pc)) begin n_fail++; $display("FAIL rnd_pred[%0d]: got %b want %b", c, pred_taken, m_pred(if_pc)); end
            n_tests++; if (flush !== exp_flush()) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", c, flush, exp_flush()); end
            n_tests++; if (redirect_valid !== exp_misp()) begin n_fail++; $display("FAIL rnd_rv[%0d]: got %b want %b", c, redirect_valid, exp_misp()); end
            if (exp_misp()) begin
                n_tests++; if (redirect_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_rpc[%0d]: got %h want %h", c, redirect_pc, exp_pc); end
            end
            n_tests++; if (br_count !== m_br || mis_count !== m_mis) begin n_fail++; $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", c, br_count, mis_count, m_br, m_mis); end
            tick();
        end
        rst_n = 1'b1;
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_saturation();
        drive_idle();
        @(negedge clk);
        force dut.mis_count_d = 32'hFFFF_FFFD;
        force dut.br_count_d  = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.mis_count_d;
        release dut.br_count_d;
        m_mis = 32'hFFFF_FFFD;
        m_br  = 32'hFFFF_FFFE;
        m_in_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_ex(2'b01, 32'h80, 32'h44, 1'b0, 1'b1);
            @(negedge clk);
            n_tests++; if (mis_count !== m_mis || br_count !== m_br) begin n_fail++; $display("FAIL sat_step[%0d]: got %h/%h want %h/%h", i, br_count, mis_count, m_br, m_mis); end
            tick();
            drive_idle();
            tick();
        end
        @(negedge clk);
        n_tests++; if (mis_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_mis: got %h want ffffffff", mis_count); end
        n_tests++; if (br_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_br: got %h want ffffffff", br_count); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        rst_n = 1'b0;
        if_pc = 32'h0;
        drive_idle();
        test_reset();
        test_train();
        test_mispredict();
        test_jump();
        test_stall();
        test_wrap();
        test_reset_in_flush();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
